// File: rtl/td4_prog_loader.sv
// TD4 program memory with a host byte-stream load port; holds the CPU in reset
// until a full image plus a matching checksum byte has been received.
module td4_prog_loader #(
    parameter int ADR_W  = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADR_W-1:0]  adr,
    output logic [DATA_W-1:0] instr,
    input  logic              load_start,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              cpu_hold,
    output logic              busy,
    output logic              load_done,
    output logic              load_err
);
    localparam int DEPTH = 1 << ADR_W;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_CHECK = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_ERROR = 3'd4;

    logic [2:0]        r_state;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADR_W-1:0]  r_wptr;
    logic [DATA_W-1:0] r_sum;
    logic              r_hold;
    logic              r_done;

    logic              w_busy;
    logic              w_ready;
    logic              w_accept;
    logic [DATA_W-1:0] w_sum_chk;

    assign w_busy    = (r_state == S_LOAD) || (r_state == S_CHECK);
    // A byte coinciding with load_start belongs to neither the old nor the new image.
    assign w_ready   = w_busy && !load_start;
    assign w_accept  = wr_valid && w_ready;
    assign w_sum_chk = r_sum + wr_data;

    assign instr     = r_mem[adr];
    assign wr_ready  = w_ready;
    assign busy      = w_busy;
    assign cpu_hold  = r_hold;
    assign load_done = r_done;
    assign load_err  = (r_state == S_ERROR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_wptr  <= '0;
            r_sum   <= '0;
            r_hold  <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (load_start) begin
                r_state <= S_LOAD;
                r_wptr  <= '0;
                r_sum   <= '0;
                r_hold  <= 1'b1;
            end else begin
                case (r_state)
                    S_LOAD: begin
                        if (w_accept) begin
                            r_wptr <= r_wptr + 1'b1;
                            r_sum  <= w_sum_chk;
                            if (&r_wptr) r_state <= S_CHECK;
                        end
                    end
                    S_CHECK: begin
                        // Image bytes plus checksum must sum to zero mod 256.
                        if (w_accept) begin
                            if (w_sum_chk == '0) begin
                                r_state <= S_RUN;
                                r_hold  <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= S_ERROR;
                            end
                        end
                    end
                    S_IDLE, S_RUN, S_ERROR: ;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // Only image bytes reach the array; the checksum byte is never stored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (r_state == S_LOAD && w_accept) begin
            r_mem[r_wptr] <= wr_data;
        end
    end
endmodule

// File: tb/tb_td4_prog_loader.sv
// Directed bench for td4_prog_loader: stimulus pushes expected probe results and
// load_done cycles into queues; a negedge monitor pops and compares them.
module tb_td4_prog_loader;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] adr = '0;
    logic [7:0] instr;
    logic       load_start = 1'b0;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = '0;
    logic       wr_ready, cpu_hold, busy, load_done, load_err;

    td4_prog_loader #(.ADR_W(4), .DATA_W(8)) dut (
        .clk(clk), .reset(reset), .adr(adr), .instr(instr),
        .load_start(load_start), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(wr_ready), .cpu_hold(cpu_hold), .busy(busy),
        .load_done(load_done), .load_err(load_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [7:0] instr;
        logic       hold, bsy, err, rdy;
    } exp_t;

    exp_t q_exp[$];
    int   q_done[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   pid = 0;
    logic chk_req = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic probe(input logic [3:0] a, input logic [7:0] ei,
                         input logic eh, input logic eb, input logic ee, input logic er);
        exp_t e;
        adr = a;
        chk_req = 1'b1;
        e.id = pid; e.instr = ei; e.hold = eh; e.bsy = eb; e.err = ee; e.rdy = er;
        pid++;
        q_exp.push_back(e);
        tick();
        chk_req = 1'b0;
    endtask

    task automatic send(input logic [7:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic start_load(input int lat);
        load_start = 1'b1;
        if (lat > 0) q_done.push_back(cyc + lat);
        tick();
        load_start = 1'b0;
    endtask

    task automatic cmp(input string nm, input int id, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s probe %0d: got %h expected %h", nm, id, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        int   x;
        if (chk_req) begin
            if (q_exp.size() == 0) begin
                checks++; errors++;
                $display("FAIL probe_queue: empty at cycle %0d", cyc);
            end else begin
                e = q_exp.pop_front();
                cmp("instr",    e.id, instr,            e.instr);
                cmp("cpu_hold", e.id, {7'd0, cpu_hold}, {7'd0, e.hold});
                cmp("busy",     e.id, {7'd0, busy},     {7'd0, e.bsy});
                cmp("load_err", e.id, {7'd0, load_err}, {7'd0, e.err});
                cmp("wr_ready", e.id, {7'd0, wr_ready}, {7'd0, e.rdy});
            end
        end
        if (load_done === 1'b1) begin
            checks++;
            if (q_done.size() == 0) begin
                errors++;
                $display("FAIL load_done: unexpected pulse at cycle %0d", cyc);
            end else begin
                x = q_done.pop_front();
                if (x != cyc) begin
                    errors++;
                    $display("FAIL load_done: pulse at cycle %0d expected cycle %0d", cyc, x);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // reset state
        tick(); tick();
        probe(4'd0, 8'h00, 1, 0, 0, 0);
        probe(4'd15, 8'h00, 1, 0, 0, 0);
        reset = 1'b1;
        tick();
        probe(4'd3, 8'h00, 1, 0, 0, 0);

        // 1: image 0..15, good checksum, back-to-back
        start_load(18);
        for (int i = 0; i < 16; i++) send(8'(i));
        send(8'h88);
        probe(4'd5, 8'h05, 0, 0, 0, 0);
        probe(4'd15, 8'h0F, 0, 0, 0, 0);

        // 2: bad checksum -> ERROR, memory keeps the image
        start_load(0);
        for (int i = 0; i < 16; i++) send(8'(i));
        send(8'h87);
        for (int i = 0; i < 16; i++) probe(4'(i), 8'(i), 1, 0, 1, 0);
        wr_valid = 1'b1; wr_data = 8'hEE;
        probe(4'd0, 8'h00, 1, 0, 1, 0);
        probe(4'd0, 8'h00, 1, 0, 1, 0);
        wr_valid = 1'b0;

        // 3: one bubble after every byte
        start_load(34);
        for (int i = 0; i < 16; i++) begin
            send(8'(i));
            probe(4'(i), 8'(i), 1, 1, 0, 1);
        end
        send(8'h88);
        probe(4'd15, 8'h0F, 0, 0, 0, 0);

        // 4: restart mid-load with a simultaneous byte, then full reload of 0x30
        start_load(0);
        for (int i = 0; i < 7; i++) send(8'h11);
        load_start = 1'b1; wr_valid = 1'b1; wr_data = 8'hAA;
        q_done.push_back(cyc + 19);
        probe(4'd7, 8'h07, 1, 1, 0, 0);
        load_start = 1'b0; wr_valid = 1'b0;
        probe(4'd7, 8'h07, 1, 1, 0, 1);
        for (int i = 0; i < 16; i++) send(8'h30);
        send(8'h00);
        for (int i = 0; i < 16; i++) probe(4'(i), 8'h30, 0, 0, 0, 0);

        // 6: writes ignored in RUN
        wr_valid = 1'b1; wr_data = 8'hFF;
        for (int i = 0; i < 16; i++) probe(4'(i), 8'h30, 0, 0, 0, 0);
        wr_valid = 1'b0;

        // 5: reset mid-load
        start_load(0);
        for (int i = 0; i < 10; i++) send(8'h55);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) probe(4'(i), 8'h00, 1, 0, 0, 0);
        reset = 1'b1;
        tick();
        probe(4'd0, 8'h00, 1, 0, 0, 0);
        wr_valid = 1'b1; wr_data = 8'h77;
        probe(4'd0, 8'h00, 1, 0, 0, 0);
        probe(4'd0, 8'h00, 1, 0, 0, 0);
        wr_valid = 1'b0;
        tick(); tick();

        checks++;
        if (q_done.size() != 0) begin
            errors++;
            $display("FAIL load_done_missing: %0d pending expected 0", q_done.size());
        end
        checks++;
        if (q_exp.size() != 0) begin
            errors++;
            $display("FAIL probe_pending: %0d pending expected 0", q_exp.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
